// File: rtl/sm_feeder_mc_pkg.sv
// sm_feeder_mc_pkg: shared index-width helper and error-flag bit positions for the feeder
package sm_feeder_mc_pkg;
    localparam int ERR_ZERO = 0;
    localparam int ERR_OVER = 1;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sm_feeder_mc_chan.sv
// sm_feeder_mc_chan: one feeder channel, a target shift register with base counter plus its ID FIFO
module sm_feeder_mc_chan
    import sm_feeder_mc_pkg::*;
#(
    parameter int TARGET_LENGTH = 128,
    parameter int LEN_WIDTH     = 12,
    parameter int ID_WIDTH      = 48,
    parameter int ID_DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic [2*TARGET_LENGTH-1:0] tgt,
    input  logic [LEN_WIDTH-1:0]       len,
    input  logic [ID_WIDTH-1:0]        id,
    input  logic                       feed,
    input  logic                       pop,
    output logic                       en,
    output logic                       done,
    output logic [1:0]                 base,
    output logic [ID_WIDTH-1:0]        id_head,
    output logic                       fifo_full
);
    localparam int AW = idx_w(ID_DEPTH);
    localparam int CW = idx_w(ID_DEPTH + 1);

    logic [2*TARGET_LENGTH-1:0] tgt_r;
    logic [LEN_WIDTH-1:0]       len_r;
    logic [LEN_WIDTH-1:0]       cnt;
    logic [ID_WIDTH-1:0]        mem [ID_DEPTH];
    logic [AW-1:0]              wp;
    logic [AW-1:0]              rp;
    logic [CW-1:0]              count;
    logic                       pop_ok;

    assign base      = tgt_r[1:0];
    assign fifo_full = count == CW'(ID_DEPTH);
    assign pop_ok    = pop && count != '0;
    assign id_head   = mem[rp];

    // Shift one base out per selected cycle; drop enable and pulse done after the last one
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tgt_r <= '0;
            len_r <= '0;
            cnt   <= '0;
            en    <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                tgt_r <= tgt;
                len_r <= len;
                cnt   <= '0;
                en    <= 1'b1;
            end else if (feed && en) begin
                tgt_r <= tgt_r >> 2;
                cnt   <= cnt + LEN_WIDTH'(1);
                if (cnt == len_r - LEN_WIDTH'(1)) begin
                    en   <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    // ID queue: pushed on every load (allocator never loads into a full queue), popped on request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ID_DEPTH; i++) mem[i] <= '0;
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (load) begin
                mem[wp] <= id;
                wp      <= (wp == AW'(ID_DEPTH - 1)) ? '0 : wp + AW'(1);
            end
            if (pop_ok) rp <= (rp == AW'(ID_DEPTH - 1)) ? '0 : rp + AW'(1);
            count <= count + CW'(load) - CW'(pop_ok);
        end
    end
endmodule

// File: rtl/sm_feeder_mc.sv
// sm_feeder_mc: multi-channel target feeder with input buffer, round-robin allocator and slot mux
module sm_feeder_mc
    import sm_feeder_mc_pkg::*;
#(
    parameter int TARGET_LENGTH = 128,
    parameter int LEN_WIDTH     = 12,
    parameter int ID_WIDTH      = 48,
    parameter int N_CH          = 2,
    parameter int ID_DEPTH      = 4,
    localparam int CH_W         = idx_w(N_CH),
    localparam int TW           = 2 * TARGET_LENGTH,
    localparam int IN_WIDTH     = ID_WIDTH + LEN_WIDTH + TW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ld,
    input  logic [IN_WIDTH-1:0]      feed_in,
    output logic                     in_rdy,
    output logic                     full,
    input  logic [CH_W-1:0]          slot,
    output logic [1:0]               data_out,
    output logic                     data_vld,
    output logic [N_CH-1:0]          en,
    output logic [N_CH-1:0]          done,
    input  logic [N_CH-1:0]          id_re,
    output logic [N_CH*ID_WIDTH-1:0] id_out,
    output logic [1:0]               err
);
    logic                     buf_vld;
    logic [ID_WIDTH-1:0]      buf_id;
    logic [LEN_WIDTH-1:0]     buf_len;
    logic [TW-1:0]            buf_tgt;
    logic [CH_W-1:0]          rr_ptr;
    logic [CH_W-1:0]          idx;
    logic [CH_W-1:0]          pick;
    logic                     found;
    logic                     sel_ok;
    logic                     over;
    logic [N_CH-1:0]          load;
    logic [N_CH-1:0]          feed;
    logic [N_CH-1:0]          fifo_full;
    logic [N_CH-1:0][1:0]     base;
    logic [ID_WIDTH-1:0]      in_id;
    logic [LEN_WIDTH-1:0]     in_len;

    assign in_id    = feed_in[IN_WIDTH-1 -: ID_WIDTH];
    assign in_len   = feed_in[TW +: LEN_WIDTH];
    assign over     = in_len > LEN_WIDTH'(TARGET_LENGTH);
    assign in_rdy   = ~buf_vld;
    assign full     = buf_vld;
    assign sel_ok   = {1'b0, slot} < (CH_W + 1)'(N_CH);
    assign data_vld = sel_ok && en[slot];
    assign data_out = data_vld ? base[slot] : 2'b00;
    assign feed     = data_vld ? N_CH'(1) << slot : '0;

    // First free channel with room in its ID queue, scanning upward from the round-robin pointer
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        load  = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = CH_W'((int'(rr_ptr) + k) % N_CH);
            if (!found && !en[idx] && !fifo_full[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        if (buf_vld && found) load[pick] = 1'b1;
    end

    // Capture into the buffer only when it is already empty; hand it to the picked channel otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_vld <= 1'b0;
            buf_id  <= '0;
            buf_len <= '0;
            buf_tgt <= '0;
            rr_ptr  <= '0;
            err     <= '0;
        end else if (ld && !buf_vld) begin
            if (in_len == '0) begin
                err[ERR_ZERO] <= 1'b1;
            end else begin
                buf_vld <= 1'b1;
                buf_id  <= in_id;
                buf_len <= over ? LEN_WIDTH'(TARGET_LENGTH) : in_len;
                buf_tgt <= feed_in[TW-1:0];
                if (over) err[ERR_OVER] <= 1'b1;
            end
        end else if (buf_vld && found) begin
            buf_vld <= 1'b0;
            rr_ptr  <= (pick == CH_W'(N_CH - 1)) ? '0 : pick + CH_W'(1);
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        sm_feeder_mc_chan #(
            .TARGET_LENGTH(TARGET_LENGTH),
            .LEN_WIDTH    (LEN_WIDTH),
            .ID_WIDTH     (ID_WIDTH),
            .ID_DEPTH     (ID_DEPTH)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .load     (load[c]),
            .tgt      (buf_tgt),
            .len      (buf_len),
            .id       (buf_id),
            .feed     (feed[c]),
            .pop      (id_re[c]),
            .en       (en[c]),
            .done     (done[c]),
            .base     (base[c]),
            .id_head  (id_out[c*ID_WIDTH +: ID_WIDTH]),
            .fifo_full(fifo_full[c])
        );
    end
endmodule

// File: tb/tb_sm_feeder_mc.sv
// tb_sm_feeder_mc: directed scenario bench for the multi-channel feeder (3 channels, slot 3 = idle)
module tb_sm_feeder_mc;
    localparam int TL = 128;
    localparam int LW = 12;
    localparam int IW = 48;
    localparam int NC = 3;
    localparam int DP = 4;
    localparam int INW = IW + LW + 2 * TL;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ld = 1'b0;
    logic [INW-1:0]  feed_in = '0;
    logic            in_rdy;
    logic            full;
    logic [1:0]      slot = 2'd3;
    logic [1:0]      data_out;
    logic            data_vld;
    logic [NC-1:0]   en;
    logic [NC-1:0]   done;
    logic [NC-1:0]   id_re = '0;
    logic [NC*IW-1:0] id_out;
    logic [1:0]      err;
    int tests = 0;
    int errs = 0;

    sm_feeder_mc #(
        .TARGET_LENGTH(TL), .LEN_WIDTH(LW), .ID_WIDTH(IW), .N_CH(NC), .ID_DEPTH(DP)
    ) dut (
        .clk(clk), .rst(rst), .ld(ld), .feed_in(feed_in), .in_rdy(in_rdy), .full(full),
        .slot(slot), .data_out(data_out), .data_vld(data_vld), .en(en), .done(done),
        .id_re(id_re), .id_out(id_out), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        ld = 1'b0;
        slot = 2'd3;
        id_re = '0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic send(input logic [IW-1:0] id, input logic [LW-1:0] len, input logic [2*TL-1:0] tgt);
        int w;
        w = 0;
        @(negedge clk);
        feed_in = {id, len, tgt};
        ld = 1'b1;
        #1;
        while (!in_rdy && w < 50) begin
            @(negedge clk);
            #1;
            w++;
        end
        tests++;
        if (!in_rdy) begin
            errs++;
            $display("FAIL send_rdy_timeout in_rdy=%0b required 1", in_rdy);
        end
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        tests++;
        if ({in_rdy, full, en, done, err, data_vld, data_out} !== {1'b1, 1'b0, 3'b0, 3'b0, 2'b0, 1'b0, 2'b0}) begin
            errs++;
            $display("FAIL reset_state in_rdy=%b full=%b en=%b done=%b err=%b vld=%b dout=%b", in_rdy, full, en, done, err, data_vld, data_out);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic();
        logic [1:0] exp [3];
        exp = '{2'd3, 2'd1, 2'd2};
        send(48'hA1, 12'd3, 256'b10_01_11);
        #1;
        tests++;
        if ({in_rdy, full} !== 2'b01) begin
            errs++;
            $display("FAIL basic_buffered in_rdy/full=%b required 01", {in_rdy, full});
        end
        @(negedge clk);
        #1;
        tests++;
        if (en !== 3'b001 || id_out[IW-1:0] !== 48'hA1) begin
            errs++;
            $display("FAIL basic_load en=%b id0=%h required 001/a1", en, id_out[IW-1:0]);
        end
        for (int i = 0; i < 5; i++) begin
            slot = 2'(i % 2);
            #1;
            tests++;
            if (i % 2 == 0 && (data_vld !== 1'b1 || data_out !== exp[i/2])) begin
                errs++;
                $display("FAIL basic_base%0d vld=%b dout=%0d required 1/%0d", i / 2, data_vld, data_out, exp[i/2]);
            end else if (i % 2 == 1 && data_vld !== 1'b0) begin
                errs++;
                $display("FAIL basic_idle_slot vld=%b required 0", data_vld);
            end
            @(negedge clk);
        end
        slot = 2'd3;
        #1;
        tests++;
        if (done !== 3'b001 || en !== 3'b000) begin
            errs++;
            $display("FAIL basic_done done=%b en=%b required 001/000", done, en);
        end
        @(negedge clk);
        #1;
        tests++;
        if (done !== 3'b000) begin
            errs++;
            $display("FAIL basic_done_pulse done=%b required 000", done);
        end
    endtask

    task automatic test_alloc();
        do_reset();
        send(48'h10, 12'd4, 256'h00);
        send(48'h11, 12'd4, 256'hE4);
        send(48'h12, 12'd4, 256'h00);
        send(48'h13, 12'd4, 256'h1B);
        @(negedge clk);
        #1;
        tests++;
        if (in_rdy !== 1'b0 || en !== 3'b111) begin
            errs++;
            $display("FAIL alloc_all_busy in_rdy=%b en=%b required 0/111", in_rdy, en);
        end
        tests++;
        if (id_out !== {48'h12, 48'h11, 48'h10}) begin
            errs++;
            $display("FAIL alloc_order ids=%h required 12/11/10", id_out);
        end
        for (int i = 0; i < 4; i++) begin
            slot = 2'd1;
            #1;
            tests++;
            if (data_vld !== 1'b1 || data_out !== 2'(i)) begin
                errs++;
                $display("FAIL alloc_ch1_base%0d dout=%0d required %0d", i, data_out, i);
            end
            @(negedge clk);
        end
        slot = 2'd3;
        #1;
        tests++;
        if (en !== 3'b101 || in_rdy !== 1'b0 || done !== 3'b010) begin
            errs++;
            $display("FAIL alloc_free en=%b in_rdy=%b done=%b required 101/0/010", en, in_rdy, done);
        end
        @(negedge clk);
        #1;
        tests++;
        if (en !== 3'b111 || in_rdy !== 1'b1) begin
            errs++;
            $display("FAIL alloc_reload en=%b in_rdy=%b required 111/1", en, in_rdy);
        end
        slot = 2'd1;
        #1;
        tests++;
        if (data_out !== 2'd3) begin
            errs++;
            $display("FAIL alloc_reload_base dout=%0d required 3", data_out);
        end
        slot = 2'd3;
        id_re = 3'b010;
        @(negedge clk);
        id_re = '0;
        #1;
        tests++;
        if (id_out[IW +: IW] !== 48'h13) begin
            errs++;
            $display("FAIL alloc_id_pop id1=%h required 13", id_out[IW +: IW]);
        end
    endtask

    task automatic test_err();
        logic [2*TL-1:0] big;
        int n;
        logic [1:0] last;
        big = '0;
        for (int k = 0; k < TL - 1; k++) big[2*k +: 2] = 2'b01;
        big[2*TL-1 -: 2] = 2'b10;
        do_reset();
        send(48'hDEAD, 12'd0, 256'h3);
        #1;
        tests++;
        if (in_rdy !== 1'b1 || err !== 2'b01) begin
            errs++;
            $display("FAIL zero_len in_rdy=%b err=%b required 1/01", in_rdy, err);
        end
        @(negedge clk);
        #1;
        tests++;
        if (en !== 3'b000) begin
            errs++;
            $display("FAIL zero_len_en en=%b required 000", en);
        end
        send(48'h55, 12'd2, 256'h0);
        @(negedge clk);
        #1;
        tests++;
        if (en !== 3'b001 || id_out[IW-1:0] !== 48'h55) begin
            errs++;
            $display("FAIL zero_len_no_push en=%b id0=%h required 001/55", en, id_out[IW-1:0]);
        end
        send(48'hBB, 12'd200, big);
        @(negedge clk);
        #1;
        tests++;
        if (err !== 2'b11 || en !== 3'b011) begin
            errs++;
            $display("FAIL oversize_flag err=%b en=%b required 11/011", err, en);
        end
        slot = 2'd1;
        #1;
        n = 0;
        last = 2'd0;
        for (int k = 0; k < 300; k++) begin
            if (!data_vld) break;
            n++;
            last = data_out;
            @(negedge clk);
            #1;
        end
        slot = 2'd3;
        tests++;
        if (n != TL || last !== 2'b10) begin
            errs++;
            $display("FAIL oversize_clamp bases=%0d last=%0d required %0d/2", n, last, TL);
        end
    endtask

    task automatic test_fifo_full();
        logic [IW-1:0] exp [3];
        exp = '{48'hE4, 48'hF5, 48'h66};
        do_reset();
        slot = 2'd0;
        send(48'hA0, 12'd1, 256'h0);
        send(48'hB1, 12'd10, 256'h0);
        send(48'hC2, 12'd10, 256'h0);
        send(48'hD3, 12'd1, 256'h0);
        send(48'hE4, 12'd1, 256'h0);
        send(48'hF5, 12'd1, 256'h0);
        send(48'h66, 12'd1, 256'h0);
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if (in_rdy !== 1'b0 || en !== 3'b110 || id_out[IW-1:0] !== 48'hA0) begin
            errs++;
            $display("FAIL fifo_full_skip in_rdy=%b en=%b id0=%h required 0/110/a0", in_rdy, en, id_out[IW-1:0]);
        end
        id_re = 3'b001;
        @(negedge clk);
        id_re = '0;
        #1;
        tests++;
        if (id_out[IW-1:0] !== 48'hD3) begin
            errs++;
            $display("FAIL fifo_pop id0=%h required d3", id_out[IW-1:0]);
        end
        @(negedge clk);
        #1;
        tests++;
        if (in_rdy !== 1'b1) begin
            errs++;
            $display("FAIL fifo_reeligible in_rdy=%b required 1", in_rdy);
        end
        for (int i = 0; i < 3; i++) begin
            id_re = 3'b001;
            @(negedge clk);
            id_re = '0;
            #1;
            tests++;
            if (id_out[IW-1:0] !== exp[i]) begin
                errs++;
                $display("FAIL fifo_order%0d id0=%h required %h", i, id_out[IW-1:0], exp[i]);
            end
        end
        slot = 2'd3;
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(48'h99, 12'd10, {128{2'b11}});
        @(negedge clk);
        slot = 2'd0;
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        tests++;
        if (en !== 3'b000 || in_rdy !== 1'b1 || data_vld !== 1'b0 || id_out[IW-1:0] !== 48'h0) begin
            errs++;
            $display("FAIL async_reset en=%b in_rdy=%b vld=%b id0=%h required 000/1/0/0", en, in_rdy, data_vld, id_out[IW-1:0]);
        end
        @(negedge clk);
        rst = 1'b1;
        slot = 2'd3;
        send(48'h77, 12'd2, 256'h0);
        @(negedge clk);
        #1;
        tests++;
        if (en !== 3'b001 || id_out[IW-1:0] !== 48'h77) begin
            errs++;
            $display("FAIL post_reset_load en=%b id0=%h required 001/77", en, id_out[IW-1:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] vals [6];
        logic [1:0] got [$];
        vals = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd1};
        do_reset();
        fork
            begin
                for (int i = 0; i < 6; i++) send(48'(i + 32), 12'd1, 256'(vals[i]));
            end
            begin
                for (int k = 0; k < 30; k++) begin
                    @(negedge clk);
                    slot = 2'(k % 3);
                    #1;
                    if (data_vld) got.push_back(data_out);
                end
            end
        join
        slot = 2'd3;
        tests++;
        if (got.size() != 6) begin
            errs++;
            $display("FAIL b2b_count bases=%0d required 6", got.size());
        end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            tests++;
            if (got[i] !== vals[i]) begin
                errs++;
                $display("FAIL b2b_base%0d got=%0d required %0d", i, got[i], vals[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_alloc();
        test_err();
        test_fifo_full();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end
endmodule
